// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Produces 640x480@60 Hz VGA raster timing from the system clock. The
// pixel_x/pixel_y coordinates and video_on go undelayed to the image
// overlay stage. hsync, vsync and video_on are also sent through a short
// delay line, so they reach the connector aligned with that stage's
// colour output.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   pixel_tick  one-clk pulse per pixel period
//   pixel_x     horizontal counter, 0..H_TOTAL-1
//   pixel_y     vertical counter, 0..V_TOTAL-1
//   video_on    raw active-area flag, undelayed
//   frame_start one-clk pulse on the last tick of a frame
//   hsync_o     delayed hsync, active low
//   vsync_o     delayed vsync, active low
//   video_on_o  delayed video_on, used to blank the RGB output
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TICK_DIV   = 4,
  parameter int PIPE_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The divider needs at least one bit, even when TICK_DIV=1.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Each delay stage holds {hsync, vsync, video_on}. It resets to the
  // idle levels: both syncs inactive (high) and video blanked.
  localparam logic [2:0] PIPE_IDLE = 3'b110;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          h_wrap;
  logic          v_wrap;
  logic          hsync_raw;
  logic          vsync_raw;
  logic [2:0]    pipe_q [PIPE_DELAY];
  logic [2:0]    pipe_d [PIPE_DELAY];

  assign pixel_tick = (tick_cnt_q == TICK_LAST);
  assign h_wrap     = (h_cnt_q == H_LAST);
  assign v_wrap     = (v_cnt_q == V_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    if (pixel_tick) begin
      tick_cnt_d = '0;
      if (h_wrap) begin
        // The end of a line also advances the line counter, so the end
        // of the last line wraps both counters on the same edge.
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  assign video_on    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_raw   = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vsync_raw   = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  assign frame_start = pixel_tick && h_wrap && v_wrap;

  // The delay line advances on every clk, not once per pixel. Its depth
  // therefore matches the overlay stage's latency in clocks.
  always_comb begin
    pipe_d[0] = {hsync_raw, vsync_raw, video_on};
    for (int i = 1; i < PIPE_DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= PIPE_IDLE;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign pixel_x    = h_cnt_q;
  assign pixel_y    = v_cnt_q;
  assign hsync_o    = pipe_q[PIPE_DELAY-1][2];
  assign vsync_o    = pipe_q[PIPE_DELAY-1][1];
  assign video_on_o = pipe_q[PIPE_DELAY-1][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. It uses three instances:
//   a: default parameters (reset release, line timing, hsync)
//   b: a small 15x10 raster, TICK_DIV=2, PIPE_DELAY=2 (vsync, frame wrap,
//      mid-frame reset)
//   c: default raster, TICK_DIV=1, PIPE_DELAY=1
// Outputs are sampled on the falling edge. Cycle 0 is the first clk after
// reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic       a_tick, a_vid, a_fs, a_hs, a_vs, a_vo;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vid, b_fs, b_hs, b_vs, b_vo;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_vid, c_fs, c_hs, c_vs, c_vo;
  logic [9:0] c_x, c_y;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vid), .frame_start(a_fs), .hsync_o(a_hs), .vsync_o(a_vs),
    .video_on_o(a_vo)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TICK_DIV(2), .PIPE_DELAY(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vid), .frame_start(b_fs), .hsync_o(b_hs), .vsync_o(b_vs),
    .video_on_o(b_vo)
  );

  vga_timing_gen #(.TICK_DIV(1), .PIPE_DELAY(1)) dut_c (
    .clk(clk), .reset(rst_c), .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_vid), .frame_start(c_fs), .hsync_o(c_hs), .vsync_o(c_vs),
    .video_on_o(c_vo)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int first_vid_low, x_at_vid_low, x656, hs_fall, hs_rise, y1, x_at_y1;
    int x_pre, y_pre, max_x, vs_bad;
    int fs_cnt, fs_first, vs_fall, vs_low, max_y;
    int x_bad;

    repeat (3) @(posedge clk);

    // ---------------- instance a: default timing ----------------
    #1 rst_a = 1'b0;
    @(negedge clk);
    chk("a_reset_vid", a_vid, 1);
    chk("a_reset_fs", a_fs, 0);
    chk("a_reset_y", a_y, 0);
    first_vid_low = -1; x656 = -1; hs_fall = -1; hs_rise = -1; y1 = -1;
    x_at_vid_low = -1; x_at_y1 = -1; x_pre = -1; y_pre = -1; max_x = 0; vs_bad = 0;
    for (int c = 0; c < 3300; c++) begin
      if (c < 12) begin
        chk($sformatf("a_tick_c%0d", c), a_tick, (c % 4 == 3) ? 1 : 0);
        chk($sformatf("a_x_c%0d", c), a_x, c / 4);
        chk($sformatf("a_hs_c%0d", c), a_hs, 1);
        chk($sformatf("a_vs_c%0d", c), a_vs, 1);
        chk($sformatf("a_vo_c%0d", c), a_vo, (c >= 3) ? 1 : 0);
      end
      if (int'(a_x) > max_x) max_x = int'(a_x);
      if (!a_vid && first_vid_low < 0) begin
        first_vid_low = c;
        x_at_vid_low = int'(a_x);
      end
      if (a_x == 10'd656 && x656 < 0) x656 = c;
      if (!a_hs && hs_fall < 0) hs_fall = c;
      if (a_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = c;
      if (a_y == 10'd1 && y1 < 0) begin
        y1 = c;
        x_at_y1 = int'(a_x);
      end
      if (c == 3199) begin
        x_pre = int'(a_x);
        y_pre = int'(a_y);
      end
      if (a_vs !== 1'b1) vs_bad++;
      @(negedge clk);
    end
    $display("a: line run done, vid_low@%0d hs_fall@%0d y1@%0d", first_vid_low, hs_fall, y1);
    chk("a_vid_low_cycle", first_vid_low, 2560);
    chk("a_vid_low_x", x_at_vid_low, 640);
    chk("a_x656_cycle", x656, 2624);
    chk("a_hs_fall_cycle", hs_fall, 2627);
    chk("a_hs_lag", hs_fall - x656, 3);
    chk("a_hs_width", hs_rise - hs_fall, 384);
    chk("a_x_before_wrap", x_pre, 799);
    chk("a_y_before_wrap", y_pre, 0);
    chk("a_wrap_cycle", y1, 3200);
    chk("a_x_after_wrap", x_at_y1, 0);
    chk("a_max_x", max_x, 799);
    chk("a_vs_stayed_high", vs_bad, 0);

    // ---------------- instance b: small raster ----------------
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("b_c0_x", b_x, 0);
    chk("b_c0_y", b_y, 0);
    chk("b_c0_tick", b_tick, 0);
    chk("b_c0_fs", b_fs, 0);
    chk("b_c0_hs", b_hs, 1);
    chk("b_c0_vs", b_vs, 1);
    chk("b_c0_vo", b_vo, 0);
    fs_cnt = 0; fs_first = -1; vs_fall = -1; vs_low = 0; max_y = 0;
    for (int c = 0; c < 701; c++) begin
      if (b_fs) begin
        fs_cnt++;
        if (fs_first < 0) begin
          fs_first = c;
          chk("b_fs_x", b_x, 14);
          chk("b_fs_y", b_y, 9);
        end
      end
      if (c == 300) begin
        chk("b_after_fs_x", b_x, 0);
        chk("b_after_fs_y", b_y, 0);
      end
      if (!b_vs && vs_fall < 0) vs_fall = c;
      if (!b_vs && c < 300) vs_low++;
      if (int'(b_y) > max_y) max_y = int'(b_y);
      @(negedge clk);
    end
    $display("b: frames done, fs_count=%0d vs_fall@%0d vs_low=%0d", fs_cnt, vs_fall, vs_low);
    chk("b_fs_count", fs_cnt, 2);
    chk("b_fs_first", fs_first, 299);
    chk("b_vs_fall", vs_fall, 212);
    chk("b_vs_low_len", vs_low, 60);
    chk("b_max_y", max_y, 9);
    // Cycle 701 is pixel (5,3) with the divider mid-count.
    chk("b_pre_rst_x", b_x, 5);
    chk("b_pre_rst_y", b_y, 3);
    chk("b_pre_rst_tick", b_tick, 1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_rst_x", b_x, 0);
    chk("b_rst_y", b_y, 0);
    chk("b_rst_tick", b_tick, 0);
    chk("b_rst_hs", b_hs, 1);
    chk("b_rst_vs", b_vs, 1);
    chk("b_rst_vo", b_vo, 0);
    @(negedge clk);
    chk("b_rs1_tick", b_tick, 1);
    chk("b_rs1_x", b_x, 0);
    chk("b_rs1_vo", b_vo, 0);
    @(negedge clk);
    chk("b_rs2_x", b_x, 1);
    chk("b_rs2_tick", b_tick, 0);
    chk("b_rs2_vo", b_vo, 1);
    $display("b: mid-frame reset recovered");

    // ---------------- instance c: TICK_DIV=1, PIPE_DELAY=1 ----------------
    @(posedge clk);
    #1 rst_c = 1'b0;
    @(negedge clk);
    hs_fall = -1; hs_rise = -1; x_bad = 0;
    for (int c = 0; c < 900; c++) begin
      if (c == 0) begin
        chk("c_c0_tick", c_tick, 1);
        chk("c_c0_hs", c_hs, 1);
        chk("c_c0_vo", c_vo, 0);
      end
      if (c == 1) chk("c_c1_vo", c_vo, 1);
      if (c < 800 && int'(c_x) != c) x_bad++;
      if (c == 800) begin
        chk("c_wrap_x", c_x, 0);
        chk("c_wrap_y", c_y, 1);
      end
      if (!c_hs && hs_fall < 0) hs_fall = c;
      if (c_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = c;
      @(negedge clk);
    end
    $display("c: line run done, hs_fall@%0d hs_rise@%0d", hs_fall, hs_rise);
    chk("c_x_every_clk", x_bad, 0);
    chk("c_hs_fall", hs_fall, 657);
    chk("c_hs_width", hs_rise - hs_fall, 96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock and feeds the on-screen image overlay stage. It supplies the `pixel_x`/`pixel_y` coordinates that stage decodes. It also delays `hsync`, `vsync` and `video_on` to match that stage's 3-clock colour latency, so sync and blanking reach the connector aligned with `rgb`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `TICK_DIV`, 4, clk cycles per pixel; must be ≥1
- `PIPE_DELAY`, 3, clk-cycle delay on the `_o` outputs; must be ≥1

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `pixel_tick`  out  1  one-clk pulse per pixel period
- `pixel_x`  out  10  horizontal counter, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical counter, 0..V_TOTAL-1
- `video_on`  out  1  raw active-area flag, undelayed
- `frame_start`  out  1  one-clk pulse on the last tick of a frame
- `hsync_o`  out  1  delayed hsync, active low
- `vsync_o`  out  1  delayed vsync, active low
- `video_on_o`  out  1  delayed `video_on`, for blanking the RGB output

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.

Tick divider:
- `tick_cnt` counts 0..TICK_DIV-1 and wraps to 0.
- `pixel_tick` = (`tick_cnt` == TICK_DIV-1), combinational.
- When TICK_DIV=1, `pixel_tick` is constantly 1 outside reset.

Counters:
- `h_cnt` and `v_cnt` change only on a clk edge where `pixel_tick`=1.
- `h_cnt` increments; at H_TOTAL-1 it wraps to 0.
- `v_cnt` increments only when `h_cnt` wraps; at V_TOTAL-1 it wraps to 0.
- `pixel_x` = `h_cnt`; `pixel_y` = `v_cnt`. Both are registered and hold steady for TICK_DIV clks.

Raw decode (combinational from the counters):
- `video_on` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- `hsync_raw` = 0 when H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- `vsync_raw` = 0 when V_ACTIVE+V_FP ≤ `v_cnt` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `frame_start` = `pixel_tick` && `h_cnt`==H_TOTAL-1 && `v_cnt`==V_TOTAL-1.

Delay line:
- A PIPE_DELAY-deep shift register, clocked every clk (not per tick), carries {`hsync_raw`, `vsync_raw`, `video_on`}.
- Its outputs drive `hsync_o`, `vsync_o` and `video_on_o`.

Reset:
- Reset has priority over ticks.
- `tick_cnt`, `h_cnt` and `v_cnt` go to 0.
- Every delay stage goes to hsync=1, vsync=1, video_on=0.
- Reset asserted mid-frame returns to pixel (0,0) on the next edge. There is no partial-line completion.

## Timing
Values during reset and in the first clk after its release:
- `pixel_x`=0, `pixel_y`=0, `pixel_tick`=0 (when TICK_DIV>1).
- `video_on`=1, because it decodes the (0,0) counters.
- `frame_start`=0.
- `hsync_o`=1, `vsync_o`=1, `video_on_o`=0.

Tick and counter timing:
- The first `pixel_tick` occurs in clk cycle TICK_DIV-1 after release (cycle 3 for the default).
- `pixel_x` becomes 1 on the following edge.

Period lengths:
- Line: H_TOTAL×TICK_DIV = 3200 clk.
- Frame: 3200×525 = 1,680,000 clk, which gives 59.52 Hz.

Output latency:
- `hsync_o`, `vsync_o` and `video_on_o` equal the raw signals exactly PIPE_DELAY clks earlier.
- After reset release, the first PIPE_DELAY clks show the reset values (1/1/0).

Wrap coincidence:
- `frame_start`, `h_cnt` wrap and `v_cnt` wrap all occur on the same edge.
- `pixel_y` never takes the value 525; `pixel_x` never takes the value 800.

## Test plan
- Reset release, default parameters:
  - `pixel_tick` is high in cycles 3, 7, 11, …
  - `pixel_x` reads 0,0,0,0,1,1,1,1,…
  - `hsync_o`/`vsync_o` stay 1 and `video_on_o` stays 0 for the first 3 clks.
- Run one line:
  - `pixel_x` steps 799→0 while `pixel_y` steps 0→1, on the same edge.
  - `video_on` goes low exactly when `pixel_x`=640.
- Horizontal sync:
  - `hsync_o` goes low 3 clks after `pixel_x` first reads 656.
  - It stays low for 96×4=384 clks.
- Vertical sync and frame wrap:
  - `vsync_o` is low only for `pixel_y`=490..491, i.e. 6400 clks.
  - `frame_start` pulses exactly once per 1,680,000 clks, at (799,524).
  - On the next edge the counters read (0,0).
- Reset mid-frame:
  - Assert at (300,200) for 1 clk.
  - Next edge: counters (0,0), `tick_cnt`=0, all delay stages at 1/1/0.
  - Normal cadence resumes afterwards.
- Parameter override TICK_DIV=1, PIPE_DELAY=1:
  - `pixel_x` increments every clk.
  - `hsync_o` is low 1 clk after `pixel_x`=656, for 96 clks.
